nexthop_table: RTL
==================

NEXTHOP_TABLE -- requirements
Module: nexthop_table

Interface
REQ-001 Parameter: NUM_CH, default 5, number of independent input channels (1..8).
REQ-002 Parameter: ADDR_W, default 3, next-hop address width in bits (1..8).
REQ-003 Parameter: TIMEOUT, default 255, lock-age limit in cycles (1..2^16-1).
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: nh_write_i  input  NUM_CH  per-channel write request (head flit routed).
REQ-007 Port: nh_address_i  input  NUM_CH*ADDR_W  per-channel next-hop address, channel c at bits [c*ADDR_W +: ADDR_W].
REQ-008 Port: nh_release_i  input  NUM_CH  per-channel release request (tail flit sent).
REQ-009 Port: nh_address_o  output  NUM_CH*ADDR_W  registered next-hop address per channel, same packing as nh_address_i.
REQ-010 Port: nh_valid_o  output  NUM_CH  1 while the channel is LOCKED.
REQ-011 Port: nh_timeout_o  output  NUM_CH  sticky flag: lock age reached TIMEOUT.
REQ-012 Port: nh_err_o  output  NUM_CH  one-cycle pulse: write rejected because the channel was locked.
REQ-013 Port: locked_count_o  output  $clog2(NUM_CH+1)  number of channels currently LOCKED.

Function
REQ-014 Each channel SHALL run an independent two-state FSM: IDLE, LOCKED.
REQ-015 IDLE and nh_write_i=1: latch nh_address_i, go to LOCKED; nh_valid_o and nh_address_o update on the following cycle (1-cycle latency).
REQ-016 IDLE and nh_release_i=1 without write: no effect.
REQ-017 IDLE and both write and release: write wins and the release is ignored.
REQ-018 LOCKED and release only: go to IDLE next cycle; nh_address_o holds its last value; nh_valid_o=0.
REQ-019 LOCKED and write only: address unchanged, state unchanged, nh_err_o=1 for exactly the next cycle.
REQ-020 LOCKED and both write and release: back-to-back packet; stay LOCKED, load the new address, clear the age and timeout; no error.
REQ-021 Per-channel age counter (width $clog2(TIMEOUT+1)): cleared on entry to LOCKED, increments each LOCKED cycle, saturates at TIMEOUT.
REQ-022 nh_timeout_o SHALL be set on the cycle after age reaches TIMEOUT and SHALL clear on release or reload; it does not force release.
REQ-023 locked_count_o SHALL be registered and equal the popcount of nh_valid_o in the same cycle.
REQ-024 Channels SHALL NOT interact; simultaneous events on all channels are legal.

Reset
REQ-025 Reset assertion SHALL asynchronously force every channel to IDLE and clear all state.
REQ-026 During reset all outputs SHALL read 0: nh_address_o, nh_valid_o, nh_timeout_o, nh_err_o and locked_count_o.
REQ-027 Reset mid-packet SHALL discard the lock; after deassertion the first write is accepted as from IDLE.
REQ-028 Reset deassertion is synchronised externally; no inputs are sampled while reset is low.

Structure
REQ-029 Shared package noc_pkg SHALL hold the nh_state_t enum (IDLE, LOCKED) and the default ADDR_W constant.
REQ-030 Per-channel logic SHALL be one sub-module, nexthop_channel (FSM, address register, age counter, error pulse), instantiated NUM_CH times by a generate loop.
REQ-031 The top level SHALL contain only the generate loop, bus slicing and the locked_count_o popcount register.

Verification
REQ-032 Reset, then write ch0 with addr 3'b101 -> next cycle nh_valid_o[0]=1, nh_address_o[2:0]=3'b101, locked_count_o=1.
REQ-033 ch0 locked at 5, write addr 2 -> address stays 5 and nh_err_o[0] pulses for 1 cycle; then release -> nh_valid_o[0]=0, count=0.
REQ-034 ch1 locked at 4, same-cycle write 6 + release -> stays valid, address becomes 6, no error, age restarts at 0.
REQ-035 TIMEOUT=4, lock ch2 with no release -> nh_timeout_o[2] rises 5 cycles after lock and stays high until release.
REQ-036 All 5 channels written in one cycle -> count=5; reset pulsed low mid-lock -> all outputs immediately 0; a write after deassertion is accepted.
REQ-037 IDLE ch3 with release only -> no output change and count unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and defaults for the next-hop table
// Purpose: per-channel lock state encoding and the default address width.
// Ports: none (package).
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } nh_state_t;

  localparam int ADDR_W_DEFAULT = 3;

endpackage

// File: rtl/nexthop_channel.sv
// rtl/nexthop_channel.sv - one channel of the next-hop lock table
// Purpose: holds the routed next-hop address between head and tail flit,
//          ages the lock, flags timeouts and rejected writes.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   write_i        head flit routed: request to lock addr_i
//   release_i      tail flit sent: request to unlock
//   addr_i         next-hop address to latch
//   addr_o         registered next-hop address (held after release)
//   valid_o        channel is locked
//   valid_next_o   lock state that becomes valid_o on the next edge
//   timeout_o      sticky: lock age reached TIMEOUT
//   err_o          one-cycle pulse: write rejected while locked
module nexthop_channel
  import noc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_i,
  input  logic              release_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  output logic              valid_next_o,
  output logic              timeout_o,
  output logic              err_o
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  nh_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      age_q     <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      age_q     <= age_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    age_d     = age_q;
    timeout_d = timeout_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous release is ignored: the write wins.
        if (write_i) begin
          state_d   = LOCKED;
          addr_d    = addr_i;
          age_d     = '0;
          timeout_d = 1'b0;
        end
      end
      LOCKED: begin
        if (write_i && release_i) begin
          // Tail of one packet and head of the next in the same cycle.
          addr_d    = addr_i;
          age_d     = '0;
          timeout_d = 1'b0;
        end else if (release_i) begin
          state_d   = IDLE;
          age_d     = '0;
          timeout_d = 1'b0;
        end else begin
          err_d = write_i;
          // Age saturates; the flag rises the cycle after saturation.
          if (age_q == AGE_MAX) begin
            timeout_d = 1'b1;
          end else begin
            age_d = age_q + AGE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_o       = addr_q;
  assign valid_o      = (state_q == LOCKED);
  assign valid_next_o = (state_d == LOCKED);
  assign timeout_o    = timeout_q;
  assign err_o        = err_q;

endmodule

// File: rtl/nexthop_table.sv
// rtl/nexthop_table.sv - multi-channel next-hop lock table
// Purpose: NUM_CH independent next-hop lock channels plus a registered
//          count of locked channels.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   nh_write_i       per-channel write (head flit routed)
//   nh_address_i     per-channel next-hop address, ADDR_W bits per channel
//   nh_release_i     per-channel release (tail flit sent)
//   nh_address_o     registered next-hop address, same packing
//   nh_valid_o       per-channel locked flag
//   nh_timeout_o     per-channel sticky lock-age timeout
//   nh_err_o         per-channel rejected-write pulse
//   locked_count_o   number of locked channels
module nexthop_table
  import noc_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            nh_write_i,
  input  logic [NUM_CH*ADDR_W-1:0]     nh_address_i,
  input  logic [NUM_CH-1:0]            nh_release_i,
  output logic [NUM_CH*ADDR_W-1:0]     nh_address_o,
  output logic [NUM_CH-1:0]            nh_valid_o,
  output logic [NUM_CH-1:0]            nh_timeout_o,
  output logic [NUM_CH-1:0]            nh_err_o,
  output logic [$clog2(NUM_CH+1)-1:0]  locked_count_o
);

  localparam int CNT_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] valid_next;
  logic [CNT_W-1:0]  count_q, count_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    nexthop_channel #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk          (clk),
      .rst_n        (reset),
      .write_i      (nh_write_i[c]),
      .release_i    (nh_release_i[c]),
      .addr_i       (nh_address_i[c*ADDR_W +: ADDR_W]),
      .addr_o       (nh_address_o[c*ADDR_W +: ADDR_W]),
      .valid_o      (nh_valid_o[c]),
      .valid_next_o (valid_next[c]),
      .timeout_o    (nh_timeout_o[c]),
      .err_o        (nh_err_o[c])
    );
  end

  // Counting next-state locks keeps the registered count aligned with
  // nh_valid_o in the same cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d = count_d + CNT_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign locked_count_o = count_q;

endmodule
